// File: rtl/countdown_timer.sv
// Purpose: loadable down-counter with one-cycle terminal-count pulse, optional auto-reload and sticky underflow.
// Latency: every output is registered and reflects the inputs of the previous rising clk edge (load -> count in 1 cycle).
// Backpressure: none; dec is consumed on every cycle it is high, and a dec at count 0 saturates and flags underflow.
module countdown_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             tc,
    output logic             busy,
    output logic             underflow
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q,     state_d;
    logic [WIDTH-1:0] count_q,     count_d;
    logic [WIDTH-1:0] reload_q,    reload_d;
    logic             zero_q,      zero_d;
    logic             tc_q,        tc_d;
    logic             busy_q,      busy_d;
    logic             underflow_q, underflow_d;

    // Next-state logic: load beats dec; RUN is the only state that ever holds a nonzero count.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        reload_d    = reload_q;
        underflow_d = underflow_q;
        tc_d        = 1'b0;

        if (load) begin
            count_d     = load_val;
            reload_d    = load_val;
            underflow_d = 1'b0;
            state_d     = (load_val != '0) ? ST_RUN : ST_IDLE;
        end else if (dec) begin
            unique case (state_q)
                ST_RUN: begin
                    if (count_q == ONE) begin
                        // Terminating decrement: pulse tc, then either restart the period or park in DONE.
                        tc_d = 1'b1;
                        if (auto_reload) begin
                            count_d = reload_q;
                        end else begin
                            count_d = '0;
                            state_d = ST_DONE;
                        end
                    end else begin
                        count_d = count_q - ONE;
                    end
                end
                ST_IDLE, ST_DONE: begin
                    // Count is already zero here: saturate rather than wrap, and remember the misuse.
                    count_d     = '0;
                    underflow_d = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end
            endcase
        end

        // Status flags are derived from the next state so they land in the same cycle as the count.
        zero_d = (count_d == '0);
        busy_d = (state_d == ST_RUN);
    end

    // State and registered outputs; synchronous reset has top priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            reload_q    <= '0;
            zero_q      <= 1'b1;
            tc_q        <= 1'b0;
            busy_q      <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            reload_q    <= reload_d;
            zero_q      <= zero_d;
            tc_q        <= tc_d;
            busy_q      <= busy_d;
            underflow_q <= underflow_d;
        end
    end

    assign count     = count_q;
    assign zero      = zero_q;
    assign tc        = tc_q;
    assign busy      = busy_q;
    assign underflow = underflow_q;

endmodule
